// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back data-cache controller: 32 lines x 8 words x 32 bits.
// Owns tag/valid/dirty state and sequences the external byte-writable cache RAM.
// CPU hits complete from LOOKUP; dirty victims drain word-serially over the
// write channel before a word-serial refill over the read channel.
//
// Handshakes: a write beat moves on a cycle with mem_wr_valid && mem_wr_ready;
// a refill request is taken on a cycle with mem_rd_req && mem_rd_addr_ok; a
// refill beat is taken on any cycle with mem_rd_valid while in REFILL. Valid
// side holds address and data stable until the transfer happens.
module dcache_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic [7:0]  ram_addra,
    output logic [31:0] ram_dina,
    output logic [3:0]  ram_wea,
    output logic [7:0]  ram_addrb,
    input  logic [31:0] ram_doutb,
    output logic        mem_wr_valid,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_ready,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_addr_ok,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_last
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_RFREQ  = 3'd3,
        S_REFILL = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // Latched request; address bits [1:0] are never needed
    logic        req_wr_q;
    logic [31:2] req_addr_q;
    logic [3:0]  req_wstrb_q;
    logic [31:0] req_wdata_q;

    // Line state
    logic [21:0] tag_q [32];
    logic [31:0] valid_q;
    logic [31:0] dirty_q;

    // Strobes from the next-state logic into the sequential blocks
    logic        accept;
    logic        set_dirty;
    logic        clr_dirty;
    logic        fill_line;

    logic [21:0] req_tag;
    logic [4:0]  req_idx;
    logic [2:0]  req_word;
    logic        hit;

    // The refill length is fixed, so the last-beat marker carries no information
    logic        unused_inputs;
    assign unused_inputs = ^{mem_rd_last, cpu_addr[1:0]};

    assign req_tag  = req_addr_q[31:10];
    assign req_idx  = req_addr_q[9:5];
    assign req_word = req_addr_q[4:2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Next-state and output decode; every output idles at zero
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        fill_line    = 1'b0;
        cpu_addr_ok  = 1'b0;
        cpu_data_ok  = 1'b0;
        cpu_rdata    = 32'h0;
        ram_addra    = 8'h0;
        ram_dina     = 32'h0;
        ram_wea      = 4'h0;
        ram_addrb    = 8'h0;
        mem_wr_valid = 1'b0;
        mem_wr_addr  = 32'h0;
        mem_wr_data  = 32'h0;
        mem_rd_req   = 1'b0;
        mem_rd_addr  = 32'h0;
        case (state_q)
            S_IDLE: begin
                cpu_addr_ok = 1'b1;
                if (cpu_req) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                ram_addrb = {req_idx, req_word};
                if (hit) begin
                    cpu_data_ok = 1'b1;
                    if (req_wr_q) begin
                        ram_addra = {req_idx, req_word};
                        ram_wea   = req_wstrb_q;
                        ram_dina  = req_wdata_q;
                        set_dirty = 1'b1;
                    end else begin
                        cpu_rdata = ram_doutb;
                    end
                    state_d = S_IDLE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    cnt_d   = 3'd0;
                    state_d = S_WB;
                end else begin
                    state_d = S_RFREQ;
                end
            end
            S_WB: begin
                // RAM read is combinational, so a stalled beat stays stable
                ram_addrb    = {req_idx, cnt_q};
                mem_wr_valid = 1'b1;
                mem_wr_data  = ram_doutb;
                mem_wr_addr  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
                if (mem_wr_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        clr_dirty = 1'b1;
                        cnt_d     = 3'd0;
                        state_d   = S_RFREQ;
                    end
                end
            end
            S_RFREQ: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = {req_tag, req_idx, 5'b0};
                if (mem_rd_addr_ok) begin
                    cnt_d   = 3'd0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rd_valid) begin
                    ram_addra = {req_idx, cnt_q};
                    ram_dina  = mem_rd_data;
                    ram_wea   = 4'hF;
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        fill_line = 1'b1;
                        cnt_d     = 3'd0;
                        state_d   = S_LOOKUP;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State register and beat counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the CPU request when it is accepted in IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= 30'h0;
            req_wstrb_q <= 4'h0;
            req_wdata_q <= 32'h0;
        end else if (accept) begin
            req_wr_q    <= cpu_wr;
            req_addr_q  <= cpu_addr[31:2];
            req_wstrb_q <= cpu_wstrb;
            req_wdata_q <= cpu_wdata;
        end
    end

    // Valid and dirty bits; reset discards all cached state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 32'h0;
            dirty_q <= 32'h0;
        end else begin
            if (set_dirty) dirty_q[req_idx] <= 1'b1;
            if (clr_dirty) dirty_q[req_idx] <= 1'b0;
            if (fill_line) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
        end
    end

    // Tag array; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_line) tag_q[req_idx] <= req_tag;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: RAM model, memory slave with stalls, and a flat
// word-level memory model plus direct-mapped line bookkeeping as reference.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_addr_ok, cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic [7:0]  ram_addra, ram_addrb;
    logic [31:0] ram_dina, ram_doutb;
    logic [3:0]  ram_wea;
    logic        mem_wr_valid, mem_wr_ready;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic        mem_rd_req, mem_rd_addr_ok, mem_rd_valid, mem_rd_last;
    logic [31:0] mem_rd_addr, mem_rd_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    dcache_ctrl dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_addr_ok(mem_rd_addr_ok), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last)
    );

    wire [182:0] dut_outs = {cpu_data_ok, cpu_rdata, ram_addra, ram_dina, ram_wea,
                             ram_addrb, mem_wr_valid, mem_wr_addr, mem_wr_data,
                             mem_rd_req, mem_rd_addr};

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- cache RAM model ----------------
    logic [31:0] cram [256];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) cram[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    always_comb begin
        ram_doutb = cram[ram_addrb];
        if (ram_addra == ram_addrb)
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) ram_doutb[8*b +: 8] = ram_dina[8*b +: 8];
    end

    // ---------------- memories (backing store and reference view) ----------------
    logic [31:0] back_mem [int unsigned];
    logic [31:0] ref_mem  [int unsigned];
    logic [21:0] ref_tag   [32];
    logic        ref_valid [32];
    logic        ref_dirty [32];
    logic [31:0] exp_wb_addr_q [$];
    logic [31:0] exp_wb_data_q [$];
    logic [31:0] wb_addr_q [$];
    logic [31:0] wb_data_q [$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction
    function automatic logic [31:0] back_rd(input logic [31:0] a);
        return back_mem.exists(a) ? back_mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Reference: coherent word view + which line each index currently holds
    task automatic ref_access(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, output logic [31:0] exp_rdata,
                              output logic exp_miss, output logic [31:0] exp_rd_addr);
        logic [4:0]  idx;
        logic [21:0] tag;
        logic [31:0] waddr, a, w;
        logic [2:0]  wv;
        idx   = addr[9:5];
        tag   = addr[31:10];
        waddr = {addr[31:2], 2'b00};
        exp_miss    = !(ref_valid[idx] && ref_tag[idx] == tag);
        exp_rd_addr = {addr[31:5], 5'b0};
        exp_rdata   = 32'h0;
        if (exp_miss && ref_valid[idx] && ref_dirty[idx]) begin
            for (int i = 0; i < 8; i++) begin
                wv = i[2:0];
                a  = {ref_tag[idx], idx, wv, 2'b00};
                exp_wb_addr_q.push_back(a);
                exp_wb_data_q.push_back(ref_rd(a));
            end
        end
        if (exp_miss) begin
            ref_tag[idx]   = tag;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            w = ref_rd(waddr);
            for (int b = 0; b < 4; b++)
                if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[waddr] = w;
            ref_dirty[idx] = 1'b1;
        end else begin
            exp_rdata = ref_rd(waddr);
        end
    endtask

    task automatic ref_reset();
        ref_mem = back_mem;
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    // ---------------- memory slave ----------------
    int          rd_phase = 0;   // 0 idle, 1 request taken, 2 streaming beats
    int          rd_beat  = 0;
    logic [31:0] rd_base;
    int unsigned last_beat_cyc = 0;
    int          refill_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0;
    int          stall_beat = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    logic        wb_held = 1'b0;
    logic [31:0] held_addr, held_data;
    logic        rq_held = 1'b0;
    logic [31:0] rq_addr;

    initial begin
        mem_wr_ready = 1'b0; mem_rd_addr_ok = 1'b0; mem_rd_valid = 1'b0;
        mem_rd_last = 1'b0;  mem_rd_data = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rd_phase = 0; rd_beat = 0; wb_held = 1'b0; rq_held = 1'b0;
                mem_wr_ready = 1'b0; mem_rd_addr_ok = 1'b0; mem_rd_valid = 1'b0;
                mem_rd_last = 1'b0;
                continue;
            end
            // write-back channel
            if (mem_wr_valid) begin
                if (wb_held) begin
                    n_tests++;
                    if (mem_wr_addr !== held_addr || mem_wr_data !== held_data) begin
                        n_fail++;
                        $display("FAIL wb_hold: got %h/%h, expected held %h/%h",
                                 mem_wr_addr, mem_wr_data, held_addr, held_data);
                    end
                end
                if (stall_beat >= 0 && int'(mem_wr_addr[4:2]) == stall_beat && stall_left > 0) begin
                    mem_wr_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else if (stall_beat >= 0) begin
                    mem_wr_ready = 1'b1;
                end else begin
                    mem_wr_ready = ($urandom_range(0, 3) != 0);
                end
                if (mem_wr_ready) begin
                    wb_addr_q.push_back(mem_wr_addr);
                    wb_data_q.push_back(mem_wr_data);
                    back_mem[mem_wr_addr] = mem_wr_data;
                    wb_held = 1'b0;
                end else begin
                    wb_held = 1'b1; held_addr = mem_wr_addr; held_data = mem_wr_data;
                end
            end else begin
                mem_wr_ready = 1'($urandom_range(0, 1));
                wb_held = 1'b0;
            end
            // refill channel
            mem_rd_addr_ok = 1'b0;
            mem_rd_valid   = 1'b0;
            mem_rd_last    = 1'b0;
            mem_rd_data    = $urandom;
            if (rd_phase == 1) rd_phase = 2;
            if (rd_phase == 2) begin
                if ($urandom_range(0, 3) != 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = back_rd(rd_base + 32'(rd_beat * 4));
                    mem_rd_last  = (rd_beat == 7);
                    rd_beat++;
                    if (rd_beat == 8) begin
                        rd_phase = 0;
                        last_beat_cyc = cyc;
                    end
                end
            end else begin
                if (mem_rd_req) begin
                    if (rq_held) begin
                        n_tests++;
                        if (mem_rd_addr !== rq_addr) begin
                            n_fail++;
                            $display("FAIL rd_req_hold: got %h, expected %h", mem_rd_addr, rq_addr);
                        end
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        mem_rd_addr_ok = 1'b1;
                        rd_base = mem_rd_addr; last_rd_addr = mem_rd_addr;
                        refill_cnt++; rd_phase = 1; rd_beat = 0; rq_held = 1'b0;
                    end else begin
                        rq_held = 1'b1; rq_addr = mem_rd_addr;
                    end
                end else begin
                    rq_held = 1'b0;
                end
                mem_rd_valid = ($urandom_range(0, 3) == 0);  // ignored outside REFILL
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output int unsigned acc_cyc, output int unsigned done_cyc,
                              output logic timed_out);
        int k;
        @(negedge clk);
        k = 0;
        while (!cpu_addr_ok && k < 50) begin @(negedge clk); k++; end
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = wdata;
        acc_cyc = cyc;
        @(negedge clk);
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
        k = 0;
        while (!cpu_data_ok && k < 400) begin @(negedge clk); k++; end
        timed_out = !cpu_data_ok;
        rdata     = cpu_rdata;
        done_cyc  = cyc;
    endtask

    logic [31:0] got, exp_d, exp_ra;
    logic        to, exp_m;
    int unsigned acc, done;
    int          rc0;

    task automatic clear_logs();
        exp_wb_addr_q.delete(); exp_wb_data_q.delete();
        wb_addr_q.delete(); wb_data_q.delete();
        rc0 = refill_cnt;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (cpu_addr_ok !== 1'b1 || dut_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_in: addr_ok=%b outs=%h, expected 1 and zero", cpu_addr_ok, dut_outs);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (cpu_addr_ok !== 1'b1 || dut_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: addr_ok=%b outs=%h, expected 1 and zero", cpu_addr_ok, dut_outs);
        end
    endtask

    task automatic test_cold_miss();
        clear_logs();
        ref_access(1'b0, 32'h0000_1024, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_1024, 4'h0, 32'h0, got, acc, done, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL cold_timeout: no data_ok"); end
        n_tests++; if (got !== 32'hA1) begin n_fail++; $display("FAIL cold_data: got %h expected %h", got, 32'hA1); end
        n_tests++; if (last_rd_addr !== 32'h0000_1020) begin n_fail++; $display("FAIL cold_rd_addr: got %h expected 00001020", last_rd_addr); end
        n_tests++; if (refill_cnt != rc0 + 1) begin n_fail++; $display("FAIL cold_refills: got %0d expected %0d", refill_cnt - rc0, 1); end
        n_tests++; if (done != last_beat_cyc + 1) begin n_fail++; $display("FAIL cold_latency: data_ok cyc %0d expected %0d", done, last_beat_cyc + 1); end
        n_tests++; if (wb_addr_q.size() != 0) begin n_fail++; $display("FAIL cold_no_wb: got %0d beats expected 0", wb_addr_q.size()); end
    endtask

    task automatic test_hit();
        clear_logs();
        ref_access(1'b0, 32'h0000_1028, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_1028, 4'h0, 32'h0, got, acc, done, to);
        n_tests++; if (to || got !== 32'hA2) begin n_fail++; $display("FAIL hit_data: got %h expected %h (timeout=%b)", got, 32'hA2, to); end
        n_tests++; if (done != acc + 1) begin n_fail++; $display("FAIL hit_latency: got %0d cycles expected 1", done - acc); end
        n_tests++; if (refill_cnt != rc0 || wb_addr_q.size() != 0) begin n_fail++; $display("FAIL hit_quiet: refills %0d wb %0d expected 0 0", refill_cnt - rc0, wb_addr_q.size()); end
    endtask

    task automatic test_partial_store();
        clear_logs();
        ref_access(1'b1, 32'h0000_1020, 4'b0011, 32'hDEAD_BEEF, exp_d, exp_m, exp_ra);
        cpu_access(1'b1, 32'h0000_1020, 4'b0011, 32'hDEAD_BEEF, got, acc, done, to);
        n_tests++; if (to || done != acc + 1) begin n_fail++; $display("FAIL store_hit_latency: got %0d cycles expected 1 (timeout=%b)", done - acc, to); end
        ref_access(1'b0, 32'h0000_1020, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_1020, 4'h0, 32'h0, got, acc, done, to);
        n_tests++; if (got !== 32'h0000_BEEF || got !== exp_d) begin n_fail++; $display("FAIL store_merge: got %h expected 0000beef", got); end
        n_tests++; if (done != acc + 1) begin n_fail++; $display("FAIL store_reload_latency: got %0d cycles expected 1", done - acc); end
    endtask

    task automatic test_dirty_evict();
        clear_logs();
        ref_access(1'b0, 32'h0000_1420, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_1420, 4'h0, 32'h0, got, acc, done, to);
        n_tests++; if (wb_addr_q.size() != 8) begin n_fail++; $display("FAIL evict_beats: got %0d expected 8", wb_addr_q.size()); end
        for (int i = 0; i < 8 && i < wb_addr_q.size(); i++) begin
            n_tests++;
            if (wb_addr_q[i] !== 32'h0000_1020 + 32'(4 * i) || wb_data_q[i] !== exp_wb_data_q[i]) begin
                n_fail++;
                $display("FAIL evict_beat%0d: got %h/%h expected %h/%h", i, wb_addr_q[i], wb_data_q[i],
                         32'h0000_1020 + 32'(4 * i), exp_wb_data_q[i]);
            end
        end
        n_tests++; if (wb_data_q.size() == 0 || wb_data_q[0] !== 32'h0000_BEEF) begin n_fail++; $display("FAIL evict_first: expected 0000beef in beat 0"); end
        n_tests++; if (to || got !== exp_d || last_rd_addr !== 32'h0000_1420) begin n_fail++; $display("FAIL evict_refill: got %h rd_addr %h expected %h 00001420", got, last_rd_addr, exp_d); end
    endtask

    task automatic test_wb_stall();
        logic [31:0] d;
        d = $urandom;
        clear_logs();
        ref_access(1'b1, 32'h0000_1024, 4'hF, d, exp_d, exp_m, exp_ra);
        cpu_access(1'b1, 32'h0000_1024, 4'hF, d, got, acc, done, to);
        clear_logs();
        stall_beat = 2; stall_left = 3; stall_seen = 0;
        ref_access(1'b0, 32'h0000_1420, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_1420, 4'h0, 32'h0, got, acc, done, to);
        stall_beat = -1;
        n_tests++; if (stall_seen != 3) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 3", stall_seen); end
        n_tests++;
        if (wb_addr_q != exp_wb_addr_q || wb_data_q != exp_wb_data_q) begin
            n_fail++;
            $display("FAIL stall_beats: got %0d beats expected %0d, or contents differ", wb_addr_q.size(), exp_wb_addr_q.size());
        end
        n_tests++; if (to || got !== exp_d) begin n_fail++; $display("FAIL stall_load: got %h expected %h", got, exp_d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        clear_logs();
        ref_access(1'b1, 32'h0000_142C, 4'hF, d, exp_d, exp_m, exp_ra);
        cpu_access(1'b1, 32'h0000_142C, 4'hF, d, got, acc, done, to);
        ref_access(1'b0, 32'h0000_142C, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_142C, 4'h0, 32'h0, got, acc, done, to);
        n_tests++; if (to || got !== d) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", got, d); end
        n_tests++; if (done != acc + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d cycles expected 1", done - acc); end
        // zero-strobe store still dirties the line
        ref_access(1'b1, 32'h0000_2040, 4'h0, 32'hFFFF_FFFF, exp_d, exp_m, exp_ra);
        cpu_access(1'b1, 32'h0000_2040, 4'h0, 32'hFFFF_FFFF, got, acc, done, to);
        clear_logs();
        ref_access(1'b0, 32'h0000_2840, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_2840, 4'h0, 32'h0, got, acc, done, to);
        n_tests++;
        if (wb_addr_q.size() != 8 || wb_data_q.size() != 8 || wb_data_q[0] !== init_val(32'h0000_2040)) begin
            n_fail++;
            $display("FAIL zero_strb_wb: got %0d beats expected 8 with untouched data", wb_addr_q.size());
        end
    endtask

    task automatic test_reset_mid_refill();
        int k;
        clear_logs();
        @(negedge clk);
        k = 0;
        while (!cpu_addr_ok && k < 50) begin @(negedge clk); k++; end
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_3060; cpu_wstrb = 4'h0;
        @(negedge clk);
        cpu_req = 1'b0;
        k = 0;
        while (!(rd_phase == 2 && rd_beat >= 4) && k < 300) begin @(posedge clk); k++; end
        n_tests++; if (k >= 300) begin n_fail++; $display("FAIL rst_wait: refill beat 4 not reached in %0d cycles", k); end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (cpu_addr_ok !== 1'b1 || dut_outs !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outs: addr_ok=%b outs=%h, expected 1 and zero", cpu_addr_ok, dut_outs);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ref_reset();
        k = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_wr_valid || mem_rd_req || !cpu_addr_ok) k++;
        end
        n_tests++; if (k != 0) begin n_fail++; $display("FAIL rst_quiet: %0d busy cycles expected 0", k); end
        clear_logs();
        ref_access(1'b0, 32'h0000_3060, 4'h0, 32'h0, exp_d, exp_m, exp_ra);
        cpu_access(1'b0, 32'h0000_3060, 4'h0, 32'h0, got, acc, done, to);
        n_tests++; if (refill_cnt != rc0 + 1) begin n_fail++; $display("FAIL rst_remiss: got %0d refills expected 1", refill_cnt - rc0); end
        n_tests++; if (to || got !== exp_d) begin n_fail++; $display("FAIL rst_reload: got %h expected %h", got, exp_d); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        wr;
        logic [3:0]  s;
        for (int it = 0; it < 80; it++) begin
            a  = (32'($urandom_range(4, 7)) << 10) | (32'($urandom_range(8, 11)) << 5)
               | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            clear_logs();
            ref_access(wr, a, s, d, exp_d, exp_m, exp_ra);
            cpu_access(wr, a, s, d, got, acc, done, to);
            n_tests++; if (to) begin n_fail++; $display("FAIL rnd_timeout: it %0d addr %h", it, a); end
            if (!wr) begin
                n_tests++; if (got !== exp_d) begin n_fail++; $display("FAIL rnd_data: it %0d addr %h got %h expected %h", it, a, got, exp_d); end
            end
            n_tests++;
            if (wb_addr_q != exp_wb_addr_q || wb_data_q != exp_wb_data_q) begin
                n_fail++;
                $display("FAIL rnd_wb: it %0d got %0d beats expected %0d, or contents differ", it, wb_addr_q.size(), exp_wb_addr_q.size());
            end
            n_tests++;
            if (refill_cnt != rc0 + int'(exp_m)) begin n_fail++; $display("FAIL rnd_refill: it %0d got %0d refills expected %0d", it, refill_cnt - rc0, exp_m); end
            n_tests++;
            if (done != (exp_m ? last_beat_cyc + 1 : acc + 1)) begin
                n_fail++;
                $display("FAIL rnd_latency: it %0d data_ok cyc %0d expected %0d", it, done, exp_m ? last_beat_cyc + 1 : acc + 1);
            end
            if (exp_m) begin
                n_tests++; if (last_rd_addr !== exp_ra) begin n_fail++; $display("FAIL rnd_rd_addr: it %0d got %h expected %h", it, last_rd_addr, exp_ra); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 8; i++) back_mem[32'h0000_1020 + 32'(4 * i)] = 32'hA0 + 32'(i);
        ref_reset();
        test_reset();
        test_cold_miss();
        test_hit();
        test_partial_store();
        test_dirty_evict();
        test_wb_stall();
        test_back_to_back();
        test_reset_mid_refill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back data-cache controller that sequences the 256-word byte-writable `cache_ram` store for the CPU's data port. The cache holds 32 lines of 8 words. The controller owns the tag, valid and dirty state, and drives both RAM ports. It serves CPU hits, writes dirty victims back over a word-serial write channel, and refills lines over a word-serial read channel.

## Interface
- No parameters. Geometry is fixed at 32 lines × 8 words × 32 bits.
- Address split: tag = addr[31:10] (22 bits), index = addr[9:5], word = addr[4:2].
- Ports:
- `clk`  in  1  sole clock
- `resetn`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU request valid
- `cpu_wr`  in  1  1 = store, 0 = load
- `cpu_addr`  in  32  byte address; bits [1:0] are ignored
- `cpu_wstrb`  in  4  byte enables for stores
- `cpu_wdata`  in  32  store data
- `cpu_addr_ok`  out  1  request accepted this cycle
- `cpu_data_ok`  out  1  single-cycle completion pulse
- `cpu_rdata`  out  32  load data, valid only while `cpu_data_ok`
- `ram_addra`  out  8  RAM write address {index, word}
- `ram_dina`  out  32  RAM write data
- `ram_wea`  out  4  RAM byte write enables
- `ram_addrb`  out  8  RAM read address
- `ram_doutb`  in  32  RAM read data (combinational; same-address writes are forwarded)
- `mem_wr_valid`  out  1  write-back beat valid
- `mem_wr_addr`  out  32  beat word address
- `mem_wr_data`  out  32  beat data
- `mem_wr_ready`  in  1  beat accepted
- `mem_rd_req`  out  1  refill request
- `mem_rd_addr`  out  32  line base address, bits [4:0] = 0
- `mem_rd_addr_ok`  in  1  refill request accepted
- `mem_rd_valid`  in  1  refill beat valid
- `mem_rd_data`  in  32  refill beat data
- `mem_rd_last`  in  1  8th beat marker

## Operation
- States: IDLE, LOOKUP, WB, RFREQ, REFILL.
- **IDLE**
  - `cpu_addr_ok` = 1.
  - On `cpu_req`: latch wr, addr, wstrb and wdata, then go to LOOKUP.
- **LOOKUP**
  - Drive `ram_addrb` = {index, word}.
  - Hit means valid[index] is set and tag[index] equals the latched tag.
  - Load hit: `cpu_data_ok` = 1 and `cpu_rdata` = `ram_doutb`.
  - Store hit: `ram_addra` = {index, word}, `ram_wea` = wstrb, `ram_dina` = wdata, dirty[index] ← 1, and `cpu_data_ok` = 1.
  - A hit returns to IDLE.
  - Miss with the victim valid and dirty: go to WB with counter = 0. Otherwise go to RFREQ.
- **WB**
  - Drive `ram_addrb` = {index, cnt}.
  - `mem_wr_valid` = 1, `mem_wr_data` = `ram_doutb`, `mem_wr_addr` = {tag[index], index, cnt, 2'b00}.
  - cnt advances only when `mem_wr_ready` is high.
  - After beat 7 is accepted: dirty[index] ← 0, go to RFREQ.
- **RFREQ**
  - `mem_rd_req` = 1 with `mem_rd_addr` = {latched tag, index, 5'b0}.
  - Both stay stable until `mem_rd_addr_ok`. Then go to REFILL with cnt = 0.
- **REFILL**
  - Each `mem_rd_valid` beat writes `mem_rd_data` to {index, cnt} with `ram_wea` = 4'hF, then cnt++.
  - After the 8th beat: tag[index] ← latched tag, valid ← 1, dirty ← 0, go to LOOKUP. The replayed lookup then hits.
  - The controller counts beats itself. `mem_rd_last` is not used for control.
- `ram_wea` = 0 in every state except a store hit or a refill beat.
- `cpu_addr_ok` is high only in IDLE. `cpu_data_ok` is high only on a LOOKUP hit.

## Timing
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - All valid and dirty bits clear.
  - cnt = 0.
  - All outputs are 0 except `cpu_addr_ok`, which is 1 because reset lands in IDLE.
  - Tags are don't-care.
- Reset mid-operation: the in-flight request is abandoned, no further memory beats are issued, and dirty data is lost.
- Hit latency: request accepted at cycle N, `cpu_data_ok` at N+1. Hit throughput is one request per 2 cycles.
- Clean miss: `data_ok` arrives 1 cycle after the 8th refill beat (the replayed LOOKUP).
- Dirty miss: adds 8 accepted write beats before `mem_rd_req`.
- Write-back read: the RAM read is combinational, so a beat held under `mem_wr_ready` = 0 keeps a stable address and data.
- Store hit in LOOKUP: RAM write commits at the next edge. A back-to-back load to the same address in the following LOOKUP sees the new data.
- Partial `cpu_wstrb` on a store leaves the unenabled bytes unchanged. `cpu_wstrb` = 0 still completes and still sets dirty.
- `mem_rd_valid` asserted outside REFILL is ignored. `mem_wr_ready` outside WB is ignored.

## Test plan
- Cold load to 0x0000_1024 -> miss, RFREQ with `mem_rd_addr` = 0x0000_1020. Beats 0xA0..0xA7 -> `cpu_rdata` = 0xA1, 1 cycle after the last beat.
- Load to 0x0000_1028 after the previous case -> hit, `cpu_data_ok` one cycle after acceptance, `cpu_rdata` = 0xA2, no memory activity.
- Store 0xDEADBEEF with wstrb 4'b0011 to 0x0000_1020, then load it -> 0x0000BEEF.
- Load 0x0000_1420 (same index, new tag) after the store -> 8 write beats at 0x0000_1020..0x0000_103C; the first beat carries 0x0000BEEF, followed by the refill.
- Same as the previous case with `mem_wr_ready` low for 3 cycles on beat 2 -> `mem_wr_addr` and `mem_wr_data` held, no beat skipped or duplicated.
- Assert `resetn` low during refill beat 4 -> IDLE, all outputs 0 except `cpu_addr_ok` = 1. A subsequent load to the same line misses.
